// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_types_pkg
// Brief    : Shared CPU types; instruction-cache frame, address split, FSM states
// Revision : 1.0 - initial icache types
// ============================================================================
package cpu_types_pkg;

    localparam int ISETS      = 16;
    localparam int IIDX_W     = 4;
    localparam int ITAG_W     = 30 - IIDX_W;
    // Widest tag any legal SETS (>= 2) can need; narrower tags are zero-extended.
    localparam int ITAG_MAX_W = 29;

    typedef struct packed {
        logic                  valid;
        logic [ITAG_MAX_W-1:0] tag;
        logic [31:0]           data;
    } icache_frame_t;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [1:0]        bytoff;
    } icachef_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/icache_responder.sv
`default_nettype none
// ============================================================================
// Module   : icache_responder
// Brief    : Direct-mapped, one-word-block instruction cache with miss-fill FSM
// Revision : 1.0 - initial release
// ============================================================================
module icache_responder
    import cpu_types_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    input  logic        flush
);

    icache_frame_t r_frames [SETS];
    icache_state_t r_state;
    icache_state_t w_next_state;
    logic [31:0]   r_miss_addr;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [IDX_W-1:0] w_fill_idx;
    logic [TAG_W-1:0] w_fill_tag;
    icache_frame_t    w_frame;
    logic             w_tag_match;
    logic             w_miss_latch;
    logic             w_fill;
    logic             w_unused;

    assign w_idx       = imemaddr[IDX_W+1:2];
    assign w_tag       = imemaddr[31:IDX_W+2];
    assign w_fill_idx  = r_miss_addr[IDX_W+1:2];
    assign w_fill_tag  = r_miss_addr[31:IDX_W+2];
    assign w_frame     = r_frames[w_idx];
    assign w_tag_match = (w_frame.tag == ITAG_MAX_W'(w_tag));
    assign w_unused    = &{1'b0, imemaddr[1:0]};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        ihit         = 1'b0;
        imemload     = 32'h0;
        iREN         = 1'b0;
        iaddr        = 32'h0;
        w_miss_latch = 1'b0;
        w_fill       = 1'b0;
        case (r_state)
            IDLE: begin
                if (imemREN) begin
                    // A flush in this cycle makes every frame look invalid.
                    if (w_frame.valid && w_tag_match && !flush) begin
                        ihit     = 1'b1;
                        imemload = w_frame.data;
                    end else begin
                        w_miss_latch = 1'b1;
                        w_next_state = FETCH;
                    end
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = r_miss_addr;
                if (!iwait) begin
                    w_fill       = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_miss_addr <= 32'h0;
        end else if (w_miss_latch) begin
            r_miss_addr <= {imemaddr[31:2], 2'b00};
        end
    end

    // Fill is written after the flush clear so it wins for its own frame.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < SETS; i++) begin
                r_frames[i] <= '0;
            end
        end else begin
            if (flush) begin
                for (int i = 0; i < SETS; i++) begin
                    r_frames[i].valid <= 1'b0;
                end
            end
            if (w_fill) begin
                r_frames[w_fill_idx].valid <= 1'b1;
                r_frames[w_fill_idx].tag   <= ITAG_MAX_W'(w_fill_tag);
                r_frames[w_fill_idx].data  <= iload;
            end
        end
    end

endmodule : icache_responder
`default_nettype wire

// File: tb/tb_icache_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_responder
// Brief    : Directed self-checking bench for icache_responder
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_responder;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        flush;

    int errors;
    int checks;

    icache_responder dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .flush    (flush)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drives one complete miss: IDLE cycle, nwait busy cycles, then the fill cycle.
    // Returns at the negedge after the fill with the address still presented.
    task automatic run_fill(input logic [31:0] addr, input int nwait, input logic [31:0] data);
        @(negedge CLK);
        imemREN  = 1'b1;
        imemaddr = addr;
        iwait    = 1'b1;
        @(negedge CLK);
        repeat (nwait) @(negedge CLK);
        iwait = 1'b0;
        iload = data;
        @(negedge CLK);
        iwait = 1'b1;
    endtask

    task automatic test_reset();
        nRST     = 1'b0;
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0040;
        iwait    = 1'b1;
        iload    = 32'h0;
        flush    = 1'b0;
        @(negedge CLK);
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL reset_ihit: got %b want 0", ihit); end
        checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL reset_iREN: got %b want 0", iREN); end
        checks++; if (iaddr !== 32'h0) begin errors++; $display("FAIL reset_iaddr: got %h want 00000000", iaddr); end
        checks++; if (imemload !== 32'h0) begin errors++; $display("FAIL reset_imemload: got %h want 00000000", imemload); end
        imemREN = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_miss_fill();
        @(negedge CLK);
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0040;
        iwait    = 1'b1;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL miss_ihit: got %b want 0", ihit); end
        checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL miss_idle_iREN: got %b want 0", iREN); end
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            #1;
            checks++; if (iREN !== 1'b1) begin errors++; $display("FAIL wait%0d_iREN: got %b want 1", c, iREN); end
            checks++; if (iaddr !== 32'h0000_0040) begin errors++; $display("FAIL wait%0d_iaddr: got %h want 00000040", c, iaddr); end
            checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL wait%0d_ihit: got %b want 0", c, ihit); end
        end
        @(negedge CLK);
        iwait = 1'b0;
        iload = 32'h3C01_0001;
        #1;
        checks++; if (iREN !== 1'b1) begin errors++; $display("FAIL fill_iREN: got %b want 1", iREN); end
        checks++; if (iaddr !== 32'h0000_0040) begin errors++; $display("FAIL fill_iaddr: got %h want 00000040", iaddr); end
        @(negedge CLK);
        iwait = 1'b1;
        #1;
        checks++; if (ihit !== 1'b1) begin errors++; $display("FAIL after_fill_ihit: got %b want 1", ihit); end
        checks++; if (imemload !== 32'h3C01_0001) begin errors++; $display("FAIL after_fill_load: got %h want 3c010001", imemload); end
        checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL after_fill_iREN: got %b want 0", iREN); end
    endtask

    task automatic test_rehit();
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            imemREN  = 1'b1;
            imemaddr = 32'h0000_0040;
            #1;
            checks++; if (ihit !== 1'b1) begin errors++; $display("FAIL rehit%0d_ihit: got %b want 1", c, ihit); end
            checks++; if (imemload !== 32'h3C01_0001) begin errors++; $display("FAIL rehit%0d_load: got %h want 3c010001", c, imemload); end
            checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL rehit%0d_iREN: got %b want 0", c, iREN); end
        end
        imemREN = 1'b0;
        #1;
        checks++; if (imemload !== 32'h0) begin errors++; $display("FAIL noreq_load: got %h want 00000000", imemload); end
    endtask

    task automatic test_conflict();
        run_fill(32'h0000_0440, 0, 32'hDEAD_BEEF);
        #1;
        checks++; if (ihit !== 1'b1) begin errors++; $display("FAIL conflict_hit440: got %b want 1", ihit); end
        checks++; if (imemload !== 32'hDEAD_BEEF) begin errors++; $display("FAIL conflict_load440: got %h want deadbeef", imemload); end
        imemaddr = 32'h0000_0040;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL conflict_evicted40: got %b want 0", ihit); end
        @(negedge CLK);
        iwait = 1'b0;
        iload = 32'h3C01_0001;
        #1;
        checks++; if (iaddr !== 32'h0000_0040 || iREN !== 1'b1) begin errors++; $display("FAIL conflict_refetch: got iREN=%b iaddr=%h want 1/00000040", iREN, iaddr); end
        @(negedge CLK);
        iwait = 1'b1;
        imemaddr = 32'h0000_0440;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL conflict_evicted440: got %b want 0", ihit); end
        imemREN = 1'b0;
    endtask

    task automatic test_redirect();
        @(negedge CLK);
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0080;
        iwait    = 1'b1;
        @(negedge CLK);
        imemaddr = 32'h0000_0100;
        #1;
        checks++; if (iaddr !== 32'h0000_0080) begin errors++; $display("FAIL redirect_iaddr: got %h want 00000080", iaddr); end
        @(negedge CLK);
        imemREN = 1'b0;
        iwait   = 1'b0;
        iload   = 32'h1111_1111;
        #1;
        checks++; if (iREN !== 1'b1 || iaddr !== 32'h0000_0080) begin errors++; $display("FAIL redirect_hold: got iREN=%b iaddr=%h want 1/00000080", iREN, iaddr); end
        @(negedge CLK);
        iwait    = 1'b1;
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0080;
        #1;
        checks++; if (ihit !== 1'b1 || imemload !== 32'h1111_1111) begin errors++; $display("FAIL redirect_frame80: got ihit=%b load=%h want 1/11111111", ihit, imemload); end
        imemaddr = 32'h0000_0100;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL redirect_miss100: got %b want 0", ihit); end
        @(negedge CLK);
        iwait = 1'b0;
        iload = 32'h2222_2222;
        #1;
        checks++; if (iaddr !== 32'h0000_0100) begin errors++; $display("FAIL redirect_fetch100: got %h want 00000100", iaddr); end
        @(negedge CLK);
        iwait = 1'b1;
        #1;
        checks++; if (ihit !== 1'b1 || imemload !== 32'h2222_2222) begin errors++; $display("FAIL redirect_hit100: got ihit=%b load=%h want 1/22222222", ihit, imemload); end
        imemREN = 1'b0;
    endtask

    task automatic test_flush();
        run_fill(32'h0000_0004, 1, 32'hA000_0004);
        run_fill(32'h0000_0008, 0, 32'hA000_0008);
        run_fill(32'h0000_000C, 2, 32'hA000_000C);
        imemaddr = 32'h0000_0004;
        #1;
        checks++; if (ihit !== 1'b1 || imemload !== 32'hA000_0004) begin errors++; $display("FAIL flush_prehit: got ihit=%b load=%h want 1/a0000004", ihit, imemload); end
        flush = 1'b1;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL flush_forced_ihit: got %b want 0", ihit); end
        imemREN = 1'b0;
        @(negedge CLK);
        flush    = 1'b0;
        imemREN  = 1'b1;
        imemaddr = 32'h0000_000C;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL flush_cleared_c: got %b want 0", ihit); end
        imemaddr = 32'h0000_0004;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL flush_cleared_4: got %b want 0", ihit); end
        @(negedge CLK);
        #1;
        checks++; if (iREN !== 1'b1 || iaddr !== 32'h0000_0004) begin errors++; $display("FAIL flush_refetch: got iREN=%b iaddr=%h want 1/00000004", iREN, iaddr); end
        iwait = 1'b0;
        iload = 32'hB000_0004;
        @(negedge CLK);
        iwait = 1'b1;
        imemREN = 1'b0;
    endtask

    task automatic test_flush_fetch();
        @(negedge CLK);
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0008;
        @(negedge CLK);
        iwait = 1'b0;
        iload = 32'hC000_0008;
        flush = 1'b1;
        @(negedge CLK);
        iwait = 1'b1;
        flush = 1'b0;
        #1;
        checks++; if (ihit !== 1'b1 || imemload !== 32'hC000_0008) begin errors++; $display("FAIL flushfetch_fill_wins: got ihit=%b load=%h want 1/c0000008", ihit, imemload); end
        imemaddr = 32'h0000_0004;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL flushfetch_other_cleared: got %b want 0", ihit); end
        imemREN = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        @(negedge CLK);
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0040;
        @(negedge CLK);
        #1;
        checks++; if (iREN !== 1'b1) begin errors++; $display("FAIL midrst_pre_iREN: got %b want 1", iREN); end
        iwait = 1'b0;
        iload = 32'hEEEE_EEEE;
        #1;
        nRST = 1'b0;
        #1;
        checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL midrst_iREN: got %b want 0", iREN); end
        checks++; if (iaddr !== 32'h0) begin errors++; $display("FAIL midrst_iaddr: got %h want 00000000", iaddr); end
        @(negedge CLK);
        iwait = 1'b1;
        nRST  = 1'b1;
        imemaddr = 32'h0000_0008;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL midrst_old_hit: got %b want 0", ihit); end
        imemaddr = 32'h0000_0040;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL midrst_discarded: got %b want 0", ihit); end
        imemREN = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_miss_fill();
        test_rehit();
        test_conflict();
        test_redirect();
        test_flush();
        test_flush_fetch();
        test_reset_mid_fetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_icache_responder
`default_nettype wire
